// File: rtl/pc_sequencer_if.sv
// Bus bundle between the fetch-stage PC sequencer and its surroundings.
//   master : environment side (drives stall/instr/flags/redirect, observes PC outputs)
//   slave  : sequencer side (consumes control inputs, drives pc/pc_plus_inc/status)
// Signals:
//   stall, instr[15:0], flags[2:0] {N,Z,V}, reg_target, redirect_valid, redirect_target
//   pc, pc_plus_inc, fetch_valid, halted, taken_count[15:0]
interface pc_sequencer_if #(
  parameter int unsigned WIDTH = 16
);
  logic             stall;
  logic [15:0]      instr;
  logic [2:0]       flags;
  logic [WIDTH-1:0] reg_target;
  logic             redirect_valid;
  logic [WIDTH-1:0] redirect_target;
  logic [WIDTH-1:0] pc;
  logic [WIDTH-1:0] pc_plus_inc;
  logic             fetch_valid;
  logic             halted;
  logic [15:0]      taken_count;

  modport master (
    output stall, instr, flags, reg_target, redirect_valid, redirect_target,
    input  pc, pc_plus_inc, fetch_valid, halted, taken_count
  );

  modport slave (
    input  stall, instr, flags, reg_target, redirect_valid, redirect_target,
    output pc, pc_plus_inc, fetch_valid, halted, taken_count
  );
endinterface

// File: rtl/pc_sequencer.sv
// Program-counter sequencer for the fetch stage.
// Drives the fetch PC every cycle with stall, late-stage redirect, conditional branches
// (B: PC-relative, BR: register), a halt state machine and a saturating taken counter.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : pc_sequencer_if.slave (control inputs in, pc/pc_plus_inc/status out)
// Build option: define PC_HALT_DRAIN_EN to insert a DRAIN state of DRAIN_CYCLES edges
// between an HLT fetch and HALTED; otherwise HLT goes straight to HALTED.
module pc_sequencer #(
  parameter int unsigned      WIDTH        = 16,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
  parameter int unsigned      INC          = 2,
  parameter int unsigned      DRAIN_CYCLES = 4
) (
  input logic          clk,
  input logic          rst,
  pc_sequencer_if.slave bus
);

  localparam logic [3:0] OpB   = 4'hC;
  localparam logic [3:0] OpBr  = 4'hD;
  localparam logic [3:0] OpHlt = 4'hF;

  localparam logic [1:0] StRun    = 2'd0;
`ifdef PC_HALT_DRAIN_EN
  localparam logic [1:0] StDrain  = 2'd1;
  localparam int unsigned DrainW  = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
`endif
  localparam logic [1:0] StHalted = 2'd2;

  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] pc_plus_inc;
  logic [WIDTH-1:0] b_offset, b_target, branch_target;
  logic [1:0]       state_q, state_d;
  logic [15:0]      cnt_q, cnt_d;
`ifdef PC_HALT_DRAIN_EN
  logic [DrainW-1:0] drain_q, drain_d;
`else
  // Keeps DRAIN_CYCLES referenced when the drain is compiled out.
  logic unused_drain_cycles;
  assign unused_drain_cycles = ^DRAIN_CYCLES;
`endif

  logic [3:0] opcode;
  logic [2:0] cond;
  logic       flag_n, flag_z, flag_v;
  logic       cond_true, is_b, is_br, is_hlt, taken;
  logic       in_run, redirect_apply, branch_apply, count_event;

  assign opcode = bus.instr[15:12];
  assign cond   = bus.instr[11:9];
  assign flag_n = bus.flags[2];
  assign flag_z = bus.flags[1];
  assign flag_v = bus.flags[0];

  assign is_b   = (opcode == OpB);
  assign is_br  = (opcode == OpBr);
  assign is_hlt = (opcode == OpHlt);

  always_comb begin
    cond_true = 1'b0;
    case (cond)
      3'b000:  cond_true = !flag_z;
      3'b001:  cond_true = flag_z;
      3'b010:  cond_true = !flag_z && !flag_n;
      3'b011:  cond_true = flag_n;
      3'b100:  cond_true = flag_z || (!flag_z && !flag_n);
      3'b101:  cond_true = flag_n || flag_z;
      3'b110:  cond_true = flag_v;
      default: cond_true = 1'b1;
    endcase
  end

  assign pc_plus_inc = pc_q + WIDTH'(INC);
  // Sign-extend the 9-bit halfword offset, then scale to bytes; sum wraps at WIDTH bits.
  assign b_offset      = WIDTH'($signed(bus.instr[8:0])) << 1;
  assign b_target      = pc_plus_inc + b_offset;
  assign branch_target = is_br ? bus.reg_target : b_target;
  assign taken         = (is_b || is_br) && cond_true;

  assign in_run         = (state_q == StRun);
  assign redirect_apply = bus.redirect_valid && (state_q != StHalted);
  assign branch_apply   = in_run && !bus.stall && !bus.redirect_valid && taken;
  // A redirect coinciding with a taken branch is a single event.
  assign count_event    = redirect_apply || branch_apply;

  always_comb begin
    pc_d = pc_q;
    if (redirect_apply) begin
      pc_d = bus.redirect_target;
    end else if (!in_run || bus.stall || is_hlt) begin
      pc_d = pc_q;
    end else if (taken) begin
      pc_d = branch_target;
    end else begin
      pc_d = pc_plus_inc;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (count_event && (cnt_q != 16'hFFFF)) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_comb begin
    state_d = state_q;
`ifdef PC_HALT_DRAIN_EN
    drain_d = drain_q;
`endif
    case (state_q)
      StRun: begin
        if (is_hlt && !bus.stall && !bus.redirect_valid) begin
`ifdef PC_HALT_DRAIN_EN
          state_d = StDrain;
          drain_d = DrainW'(DRAIN_CYCLES - 1);
`else
          state_d = StHalted;
`endif
        end
      end
`ifdef PC_HALT_DRAIN_EN
      StDrain: begin
        if (bus.redirect_valid) begin
          // The HLT was on the wrong path.
          state_d = StRun;
          drain_d = '0;
        end else if (drain_q <= DrainW'(1)) begin
          // Counter hits 0 on this edge, so HALTED lands DRAIN_CYCLES edges after the fetch.
          state_d = StHalted;
          drain_d = '0;
        end else begin
          drain_d = drain_q - DrainW'(1);
        end
      end
`endif
      default: state_d = state_q; // HALTED is sticky until reset
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q    <= RESET_VECTOR;
      state_q <= StRun;
      cnt_q   <= '0;
`ifdef PC_HALT_DRAIN_EN
      drain_q <= '0;
`endif
    end else begin
      pc_q    <= pc_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
`ifdef PC_HALT_DRAIN_EN
      drain_q <= drain_d;
`endif
    end
  end

  assign bus.pc          = pc_q;
  assign bus.pc_plus_inc = pc_plus_inc;
  assign bus.fetch_valid = in_run && !bus.stall;
  assign bus.halted      = (state_q == StHalted);
  assign bus.taken_count = cnt_q;

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;
  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;
  logic [15:0] exp_cnt;

  pc_sequencer_if #(.WIDTH(16)) bus ();

  pc_sequencer #(
    .WIDTH       (16),
    .RESET_VECTOR(16'h0100),
    .INC         (2),
    .DRAIN_CYCLES(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic redirect_to(input logic [15:0] tgt);
    bus.redirect_valid  = 1'b1;
    bus.redirect_target = tgt;
    tick();
    bus.redirect_valid  = 1'b0;
    if (exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.stall = 1'b0; bus.instr = 16'h0000; bus.flags = 3'b000;
    bus.reg_target = 16'h0000; bus.redirect_valid = 1'b0; bus.redirect_target = 16'h0000;
    exp_cnt = 16'h0000;
    #2;
    n_tests++; if (bus.pc !== 16'h0100) begin
      $display("FAIL reset_pc got=%h exp=0100", bus.pc); n_fail++; end
    n_tests++; if (bus.pc_plus_inc !== 16'h0102) begin
      $display("FAIL reset_pc_plus_inc got=%h exp=0102", bus.pc_plus_inc); n_fail++; end
    n_tests++; if (bus.fetch_valid !== 1'b1 || bus.halted !== 1'b0) begin
      $display("FAIL reset_status fv=%b halted=%b exp 1/0", bus.fetch_valid, bus.halted);
      n_fail++; end
    n_tests++; if (bus.taken_count !== 16'h0000) begin
      $display("FAIL reset_count got=%h exp=0000", bus.taken_count); n_fail++; end
    #5;
    rst = 1'b0;
  endtask

  task automatic test_sequential();
    logic [15:0] exp_pc;
    for (int i = 1; i < 4; i++) begin
      tick();
      exp_pc = 16'h0100 + 16'(2 * i);
      n_tests++; if (bus.pc !== exp_pc) begin
        $display("FAIL seq_pc step=%0d got=%h exp=%h", i, bus.pc, exp_pc); n_fail++; end
    end
    #3 rst = 1'b1;
    #1;
    n_tests++; if (bus.pc !== 16'h0100) begin
      $display("FAIL async_reset_pc got=%h exp=0100", bus.pc); n_fail++; end
    #1 rst = 1'b0;
    exp_cnt = 16'h0000;
  endtask

  task automatic test_branch();
    logic [15:0] v_instr [9];
    logic [2:0]  v_flags [9];
    logic [15:0] v_pc    [9];
    logic        v_taken [9];
    v_instr = '{16'hDE00, 16'hC604, 16'hC804, 16'hC804, 16'hCC04,
                16'hCBFE, 16'hC1FE, 16'hC404, 16'hCF00};
    v_flags = '{3'b000, 3'b100, 3'b100, 3'b010, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000};
    v_pc    = '{16'h4000, 16'h400A, 16'h400C, 16'h4016, 16'h4018,
                16'h401A, 16'h4018, 16'h4022, 16'h3E24};
    v_taken = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

    bus.instr = 16'h0000;
    redirect_to(16'h0010);
    bus.instr = 16'hC3FE; bus.flags = 3'b010;
    tick(); exp_cnt = exp_cnt + 16'd1;
    n_tests++; if (bus.pc !== 16'h000E) begin
      $display("FAIL beq_taken_pc got=%h exp=000E", bus.pc); n_fail++; end
    n_tests++; if (bus.taken_count !== exp_cnt) begin
      $display("FAIL beq_taken_count got=%h exp=%h", bus.taken_count, exp_cnt); n_fail++; end

    bus.instr = 16'h0000;
    redirect_to(16'h0010);
    bus.instr = 16'hC3FE; bus.flags = 3'b000;
    tick();
    n_tests++; if (bus.pc !== 16'h0012) begin
      $display("FAIL beq_not_taken_pc got=%h exp=0012", bus.pc); n_fail++; end
    n_tests++; if (bus.taken_count !== exp_cnt) begin
      $display("FAIL beq_not_taken_count got=%h exp=%h", bus.taken_count, exp_cnt); n_fail++; end

    bus.reg_target = 16'h4000;
    for (int i = 0; i < 9; i++) begin
      bus.instr = v_instr[i];
      bus.flags = v_flags[i];
      tick();
      if (v_taken[i]) exp_cnt = exp_cnt + 16'd1;
      n_tests++; if (bus.pc !== v_pc[i] || bus.taken_count !== exp_cnt) begin
        $display("FAIL branch_vec%0d pc=%h cnt=%h exp pc=%h cnt=%h",
                 i, bus.pc, bus.taken_count, v_pc[i], exp_cnt);
        n_fail++; end
    end
    bus.flags = 3'b000;
  endtask

  task automatic test_stall_redirect();
    bus.stall = 1'b1; bus.instr = 16'hCE00;
    tick();
    n_tests++; if (bus.pc !== 16'h3E24 || bus.taken_count !== exp_cnt) begin
      $display("FAIL stall_branch pc=%h cnt=%h exp pc=3E24 cnt=%h",
               bus.pc, bus.taken_count, exp_cnt); n_fail++; end
    n_tests++; if (bus.fetch_valid !== 1'b0) begin
      $display("FAIL stall_fetch_valid got=%b exp=0", bus.fetch_valid); n_fail++; end
    redirect_to(16'h0200);
    n_tests++; if (bus.pc !== 16'h0200 || bus.taken_count !== exp_cnt) begin
      $display("FAIL stall_redirect pc=%h cnt=%h exp pc=0200 cnt=%h",
               bus.pc, bus.taken_count, exp_cnt); n_fail++; end
    bus.stall = 1'b0;
    redirect_to(16'h0300);
    n_tests++; if (bus.pc !== 16'h0300 || bus.taken_count !== exp_cnt) begin
      $display("FAIL redirect_with_branch pc=%h cnt=%h exp pc=0300 cnt=%h",
               bus.pc, bus.taken_count, exp_cnt); n_fail++; end
  endtask

  task automatic test_wrap();
    bus.instr = 16'h0000;
    redirect_to(16'hFFFE);
    n_tests++; if (bus.pc_plus_inc !== 16'h0000) begin
      $display("FAIL wrap_pc_plus_inc got=%h exp=0000", bus.pc_plus_inc); n_fail++; end
    tick();
    n_tests++; if (bus.pc !== 16'h0000) begin
      $display("FAIL wrap_seq got=%h exp=0000", bus.pc); n_fail++; end
    bus.instr = 16'hCFFE;
    tick(); exp_cnt = exp_cnt + 16'd1;
    n_tests++; if (bus.pc !== 16'hFFFE) begin
      $display("FAIL wrap_branch_back got=%h exp=FFFE", bus.pc); n_fail++; end
  endtask

  task automatic test_halt_blocked();
    bus.instr = 16'h0000;
    redirect_to(16'h0040);
    bus.instr = 16'hF000; bus.stall = 1'b1;
    tick();
    n_tests++; if (bus.halted !== 1'b0 || bus.pc !== 16'h0040) begin
      $display("FAIL hlt_under_stall halted=%b pc=%h exp 0/0040", bus.halted, bus.pc);
      n_fail++; end
    bus.stall = 1'b0;
    redirect_to(16'h0050);
    n_tests++; if (bus.halted !== 1'b0 || bus.fetch_valid !== 1'b1 || bus.pc !== 16'h0050) begin
      $display("FAIL hlt_with_redirect halted=%b fv=%b pc=%h exp 0/1/0050",
               bus.halted, bus.fetch_valid, bus.pc); n_fail++; end
  endtask

  task automatic test_halt();
    bus.instr = 16'h0000;
    redirect_to(16'h0020);
    bus.instr = 16'hF000;
    tick();
`ifdef PC_HALT_DRAIN_EN
    n_tests++; if (bus.fetch_valid !== 1'b0 || bus.halted !== 1'b0) begin
      $display("FAIL drain_entry fv=%b halted=%b exp 0/0", bus.fetch_valid, bus.halted);
      n_fail++; end
    bus.instr = 16'h0000;
    for (int i = 2; i <= 3; i++) begin
      tick();
      n_tests++; if (bus.halted !== 1'b0 || bus.pc !== 16'h0020) begin
        $display("FAIL drain_edge%0d halted=%b pc=%h exp 0/0020", i, bus.halted, bus.pc);
        n_fail++; end
    end
    tick();
`endif
    n_tests++; if (bus.halted !== 1'b1 || bus.fetch_valid !== 1'b0 || bus.pc !== 16'h0020) begin
      $display("FAIL halt_reached halted=%b fv=%b pc=%h exp 1/0/0020",
               bus.halted, bus.fetch_valid, bus.pc); n_fail++; end
    bus.redirect_valid = 1'b1; bus.redirect_target = 16'h0300;
    tick();
    bus.redirect_valid = 1'b0;
    n_tests++; if (bus.halted !== 1'b1 || bus.pc !== 16'h0020 || bus.taken_count !== exp_cnt) begin
      $display("FAIL halted_redirect halted=%b pc=%h cnt=%h exp 1/0020/%h",
               bus.halted, bus.pc, bus.taken_count, exp_cnt); n_fail++; end
    #1 rst = 1'b1;
    #1;
    n_tests++; if (bus.halted !== 1'b0 || bus.pc !== 16'h0100 || bus.taken_count !== 16'h0000) begin
      $display("FAIL halt_reset halted=%b pc=%h cnt=%h exp 0/0100/0000",
               bus.halted, bus.pc, bus.taken_count); n_fail++; end
    #1 rst = 1'b0;
    exp_cnt = 16'h0000;
    bus.instr = 16'h0000;
    tick();
    n_tests++; if (bus.pc !== 16'h0102 || bus.fetch_valid !== 1'b1) begin
      $display("FAIL run_after_reset pc=%h fv=%b exp 0102/1", bus.pc, bus.fetch_valid);
      n_fail++; end
  endtask

`ifdef PC_HALT_DRAIN_EN
  task automatic test_halt_cancel();
    redirect_to(16'h0020);
    bus.instr = 16'hF000;
    tick();
    bus.instr = 16'h0000;
    tick();
    redirect_to(16'h0300);
    n_tests++; if (bus.pc !== 16'h0300 || bus.fetch_valid !== 1'b1 || bus.halted !== 1'b0) begin
      $display("FAIL cancel_redirect pc=%h fv=%b halted=%b exp 0300/1/0",
               bus.pc, bus.fetch_valid, bus.halted); n_fail++; end
    for (int i = 1; i <= 4; i++) begin
      tick();
      n_tests++; if (bus.halted !== 1'b0 || bus.pc !== 16'h0300 + 16'(2 * i)) begin
        $display("FAIL cancel_run%0d halted=%b pc=%h exp 0/%h",
                 i, bus.halted, bus.pc, 16'h0300 + 16'(2 * i)); n_fail++; end
    end
  endtask
`endif

  task automatic test_saturation();
    #1 rst = 1'b1;
    #2 rst = 1'b0;
    bus.instr = 16'hDE00; bus.reg_target = 16'h1234;
    for (int i = 0; i < 65534; i++) tick();
    n_tests++; if (bus.taken_count !== 16'hFFFE) begin
      $display("FAIL sat_pre got=%h exp=FFFE", bus.taken_count); n_fail++; end
    tick();
    n_tests++; if (bus.taken_count !== 16'hFFFF) begin
      $display("FAIL sat_reach got=%h exp=FFFF", bus.taken_count); n_fail++; end
    for (int i = 0; i < 3; i++) tick();
    n_tests++; if (bus.taken_count !== 16'hFFFF || bus.pc !== 16'h1234) begin
      $display("FAIL sat_hold cnt=%h pc=%h exp FFFF/1234", bus.taken_count, bus.pc);
      n_fail++; end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    test_reset();
    test_sequential();
    test_branch();
    test_stall_redirect();
    test_wrap();
    test_halt_blocked();
    test_halt();
`ifdef PC_HALT_DRAIN_EN
    test_halt_cancel();
`endif
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
